tnoc_vc_packet_buffer: RTL and testbench
========================================

// Module: tnoc_vc_packet_buffer
// PURPOSE
//  Per-virtual-channel input buffer on the router local port, directly upstream of the local-to-internal VC arbiter/mux.
//  - Accepts a single flit stream tagged with a VC number and stores each flit in that VC's FIFO.
//  - Presents per-VC valid/flit/ready toward the arbiter.
//  - Raises vc_available[v] only while VC v can deliver a whole packet without stalling:
//    its tail is buffered, or the packet is already in flight.
// PARAMETERS
//  CHANNELS    2   number of virtual channels (>=1)
//  FLIT_WIDTH  64  flit payload width in bits
//  DEPTH       4   per-VC FIFO depth in flits (>=2, power of two)
//  (local) VC_WIDTH = max(1,$clog2(CHANNELS)); CNT_WIDTH = $clog2(DEPTH+1)
// PORTS
//  clk             in   1                    clock, all state on rising edge
//  rst_n           in   1                    reset; synchronous, active-low
//  i_valid         in   1                    input flit valid
//  o_ready         out  1                    input flit accepted this cycle
//  i_vc            in   VC_WIDTH             VC of input flit
//  i_tail          in   1                    input flit is last flit of its packet
//  i_flit          in   FLIT_WIDTH           input flit payload
//  o_valid         out  CHANNELS             VC v FIFO non-empty
//  i_ready         in   CHANNELS             downstream pops head of VC v
//  o_vc_available  out  CHANNELS             VC v may be granted (see below)
//  o_tail          out  CHANNELS             head flit of VC v is a tail
//  o_flit          out  CHANNELS*FLIT_WIDTH  head flit of VC v, slice [v*FLIT_WIDTH +: FLIT_WIDTH]
// BEHAVIOUR
//  Reset (rst_n==0 at a clk edge):
//  - every FIFO is emptied; tail_cnt[v]=0; busy[v]=0.
//  - Next cycle: o_valid=0, o_vc_available=0.
//  - o_ready=1 whenever i_vc<CHANNELS; o_flit/o_tail are don't-care while o_valid is low.
//  Push: push[v] = i_valid & o_ready & (i_vc==v).
//  - o_ready = (i_vc<CHANNELS) & !full[i_vc]. This is combinational on i_vc; o_ready does not depend on i_ready.
//  - A flit with i_vc>=CHANNELS is never accepted.
//  - The flit and i_tail are written at the edge; o_valid rises the following cycle. There is no bypass, so min latency is 1 cycle.
//  Pop: pop[v] = o_valid[v] & i_ready[v]. The head advances at the edge. Any number of VCs may pop in the same cycle.
//  Full-FIFO rule: a full VC rejects a push even while it is popping in the same cycle. There is no pop-through.
//  Empty/full flags: track occupancy with CNT_WIDTH counters or DEPTH-wrapping pointers plus a wrap bit.
//  - full = (count==DEPTH); empty = (count==0).
//  - Pointers wrap from DEPTH-1 to 0.
//  tail_cnt[v] (CNT_WIDTH) counts tail flits currently stored in VC v:
//  - +1 on a push with i_tail; -1 on a pop whose head o_tail[v]=1.
//  - Both events in the same cycle: unchanged. It never exceeds DEPTH or goes below 0.
//  busy[v] is per-VC state, 2 states:
//  - IDLE(0) -> BUSY(1) on a pop of a non-tail flit.
//  - BUSY -> IDLE on a pop of a tail flit.
//  - A single-flit packet (head=tail) leaves busy at 0.
//  o_vc_available[v] = o_valid[v] & ((tail_cnt[v]!=0) | busy[v]):
//  - A packet is never offered before its tail is buffered.
//  - Once started, the packet stays available so the arbiter lock is not broken.
//  Packets longer than DEPTH flits cannot be fully buffered:
//  - If the FIFO is full with no tail (tail_cnt==0, busy==0), o_vc_available is forced to 1 for that VC (cut-through escape) to prevent deadlock.
//  - The VC then proceeds as a normal in-flight packet.
//  VCs are fully independent; a stall on one VC never blocks pushes to another VC, except through shared o_ready for the presented i_vc.
// TESTING
//  1) Reset, then push 1 flit VC0 tail=1 data=0xA5 -> next cycle o_valid=01, o_vc_available=01, o_flit[63:0]=0xA5; pop -> o_valid=00.
//  2) Push VC1 flits head,body (tail=0) -> o_valid[1]=1, o_vc_available[1]=0.
//     Push tail -> o_vc_available[1]=1. Pop 3 flits -> it stays 1 through the body, drops after the tail.
//  3) DEPTH=4: push 4 non-tail flits to VC0 -> o_ready=0 for i_vc=0 and escape o_vc_available[0]=1.
//     With i_vc=1 the same cycle: o_ready=1 and the push succeeds.
//  4) Full VC0 with i_ready[0]=1 and i_valid to VC0 the same cycle -> push rejected; count 3 next cycle; push accepted the cycle after.
//  5) Tail push and tail pop on VC1 in the same cycle with tail_cnt=1 -> tail_cnt stays 1, o_vc_available[1] stays 1.
//  6) Assert rst_n=0 for one edge mid-packet (VC0 busy=1, 2 flits stored) -> next cycle o_valid=00, o_vc_available=00, o_ready=1; fresh packet flows normally.

Source files
------------

// File: rtl/tnoc_vc_packet_buffer.sv
// Per-virtual-channel input buffer for the router local port: one FIFO per VC,
// with packet-level availability so the VC arbiter only grants complete or in-flight packets.
module tnoc_vc_packet_buffer #(
    parameter int CHANNELS   = 2,
    parameter int FLIT_WIDTH = 64,
    parameter int DEPTH      = 4,
    localparam int VC_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNT_WIDTH = $clog2(DEPTH + 1),
    localparam int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [VC_WIDTH-1:0]            i_vc,
    input  logic                           i_tail,
    input  logic [FLIT_WIDTH-1:0]          i_flit,
    output logic [CHANNELS-1:0]            o_valid,
    input  logic [CHANNELS-1:0]            i_ready,
    output logic [CHANNELS-1:0]            o_vc_available,
    output logic [CHANNELS-1:0]            o_tail,
    output logic [CHANNELS*FLIT_WIDTH-1:0] o_flit
);

    typedef enum logic {
        VC_IDLE = 1'b0,
        VC_BUSY = 1'b1
    } vc_state_e;

    logic [CHANNELS-1:0] full_s;
    logic                in_range_s;
    logic                sel_full_s;

    // Input acceptance: only a valid VC number whose FIFO has room; independent of pops.
    always_comb begin
        in_range_s = (32'(i_vc) < 32'(CHANNELS));
        sel_full_s = 1'b0;
        for (int v = 0; v < CHANNELS; v++) begin
            sel_full_s = sel_full_s | ((i_vc == VC_WIDTH'(v)) & full_s[v]);
        end
        o_ready = in_range_s & ~sel_full_s;
    end

    for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
        logic [FLIT_WIDTH:0]  mem_q [DEPTH];
        logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
        logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
        logic [CNT_WIDTH-1:0] count_q, count_d;
        logic [CNT_WIDTH-1:0] tail_cnt_q, tail_cnt_d;
        vc_state_e            busy_q, busy_d;
        logic                 push_s, pop_s, head_tail_s;
        logic [FLIT_WIDTH:0]  head_s;

        assign head_s         = mem_q[rd_ptr_q];
        assign head_tail_s    = head_s[FLIT_WIDTH];
        assign full_s[v]      = (count_q == CNT_WIDTH'(DEPTH));
        assign o_valid[v]     = (count_q != {CNT_WIDTH{1'b0}});
        assign o_tail[v]      = head_tail_s;
        assign o_flit[v*FLIT_WIDTH +: FLIT_WIDTH] = head_s[FLIT_WIDTH-1:0];
        assign push_s         = i_valid & o_ready & (i_vc == VC_WIDTH'(v));
        assign pop_s          = o_valid[v] & i_ready[v];
        // A full FIFO without a tail is offered anyway so an over-long packet cannot deadlock.
        assign o_vc_available[v] = o_valid[v] &
            ((tail_cnt_q != {CNT_WIDTH{1'b0}}) | (busy_q == VC_BUSY) | full_s[v]);

        // Next-state for pointers, occupancy, stored-tail count and packet-in-flight state.
        always_comb begin
            wr_ptr_d   = wr_ptr_q;
            rd_ptr_d   = rd_ptr_q;
            count_d    = count_q;
            tail_cnt_d = tail_cnt_q;
            busy_d     = busy_q;
            if (push_s) begin
                wr_ptr_d = (wr_ptr_q == PTR_WIDTH'(DEPTH - 1)) ? {PTR_WIDTH{1'b0}} : wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = (rd_ptr_q == PTR_WIDTH'(DEPTH - 1)) ? {PTR_WIDTH{1'b0}} : rd_ptr_q + 1'b1;
                busy_d   = head_tail_s ? VC_IDLE : VC_BUSY;
            end else begin
                rd_ptr_d = rd_ptr_q;
                busy_d   = busy_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            case ({push_s & i_tail, pop_s & head_tail_s})
                2'b10:   tail_cnt_d = tail_cnt_q + 1'b1;
                2'b01:   tail_cnt_d = tail_cnt_q - 1'b1;
                default: tail_cnt_d = tail_cnt_q;
            endcase
        end

        // Control state registers with synchronous active-low reset.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wr_ptr_q   <= {PTR_WIDTH{1'b0}};
                rd_ptr_q   <= {PTR_WIDTH{1'b0}};
                count_q    <= {CNT_WIDTH{1'b0}};
                tail_cnt_q <= {CNT_WIDTH{1'b0}};
                busy_q     <= VC_IDLE;
            end else begin
                wr_ptr_q   <= wr_ptr_d;
                rd_ptr_q   <= rd_ptr_d;
                count_q    <= count_d;
                tail_cnt_q <= tail_cnt_d;
                busy_q     <= busy_d;
            end
        end

        // Flit storage; contents are don't-care while empty, so no reset.
        always_ff @(posedge clk) begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= {i_tail, i_flit};
            end
        end
    end

endmodule

// File: tb/tb_tnoc_vc_packet_buffer.sv
// Directed bench for tnoc_vc_packet_buffer: expected flits are queued per VC at issue time
// and a negedge monitor compares every popped head against its queue.
module tb_tnoc_vc_packet_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [0:0]   i_vc;
    logic         i_tail;
    logic [63:0]  i_flit;
    logic [1:0]   o_valid;
    logic [1:0]   i_ready;
    logic [1:0]   o_vc_available;
    logic [1:0]   o_tail;
    logic [127:0] o_flit;

    int n_checks = 0;
    int n_fail   = 0;
    logic [64:0] sb0[$];
    logic [64:0] sb1[$];

    tnoc_vc_packet_buffer #(.CHANNELS(2), .FLIT_WIDTH(64), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_vc(i_vc),
        .i_tail(i_tail), .i_flit(i_flit), .o_valid(o_valid), .i_ready(i_ready),
        .o_vc_available(o_vc_available), .o_tail(o_tail), .o_flit(o_flit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a pop happens at the next edge whenever valid & ready are seen here.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (o_valid[0] && i_ready[0]) begin
                if (sb0.size() == 0) check("pop_vc0_unexpected", {o_tail[0], o_flit[63:0]}, 65'h1_FFFF_FFFF_FFFF_FFFF);
                else check("pop_vc0", {o_tail[0], o_flit[63:0]}, sb0.pop_front());
            end
            if (o_valid[1] && i_ready[1]) begin
                if (sb1.size() == 0) check("pop_vc1_unexpected", {o_tail[1], o_flit[127:64]}, 65'h1_FFFF_FFFF_FFFF_FFFF);
                else check("pop_vc1", {o_tail[1], o_flit[127:64]}, sb1.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus; expected flits are queued when acceptance is expected.
    task automatic drive(input logic v, input logic vc, input logic t, input logic [63:0] d,
                         input logic [1:0] rdy, input logic exp_acc);
        i_valid = v; i_vc = vc; i_tail = t; i_flit = d; i_ready = rdy;
        if (v && exp_acc) begin
            if (vc == 1'b0) sb0.push_back({t, d});
            else            sb1.push_back({t, d});
        end
    endtask

    task automatic idle(input logic [1:0] rdy);
        drive(1'b0, 1'b0, 1'b0, 64'h0, rdy, 1'b0);
    endtask

    task automatic chk_vo(input string name, input logic [1:0] ev, input logic [1:0] ea);
        check({name, "_valid"}, {63'h0, o_valid}, {63'h0, ev});
        check({name, "_avail"}, {63'h0, o_vc_available}, {63'h0, ea});
    endtask

    task automatic chk_rdy(input string name, input logic er);
        check({name, "_ready"}, {64'h0, o_ready}, {64'h0, er});
    endtask

    initial begin
        rst_n = 1'b0;
        idle(2'b00);
        tick(); tick();
        @(negedge clk);
        chk_vo("reset", 2'b00, 2'b00);
        chk_rdy("reset", 1'b1);
        tick(); rst_n = 1'b1;

        // 1) single-flit packet on VC0
        drive(1'b1, 1'b0, 1'b1, 64'hA5, 2'b00, 1'b1);
        @(negedge clk); chk_rdy("t1_push", 1'b1); chk_vo("t1_pre", 2'b00, 2'b00);
        tick(); idle(2'b01);
        @(negedge clk); chk_vo("t1_head", 2'b01, 2'b01);
        check("t1_flit", {1'b0, o_flit[63:0]}, 65'hA5);
        tick(); idle(2'b00);
        @(negedge clk); chk_vo("t1_popped", 2'b00, 2'b00);

        // 2) three-flit packet on VC1, tail gating of availability
        tick(); drive(1'b1, 1'b1, 1'b0, 64'h11, 2'b00, 1'b1);
        @(negedge clk); chk_rdy("t2_p0", 1'b1);
        tick(); drive(1'b1, 1'b1, 1'b0, 64'h12, 2'b00, 1'b1);
        @(negedge clk); chk_vo("t2_head_only", 2'b10, 2'b00);
        tick(); drive(1'b1, 1'b1, 1'b1, 64'h13, 2'b00, 1'b1);
        @(negedge clk); chk_vo("t2_no_tail", 2'b10, 2'b00);
        tick(); idle(2'b00);
        @(negedge clk); chk_vo("t2_tail_in", 2'b10, 2'b10);
        for (int i = 0; i < 3; i++) begin
            tick(); idle(2'b10);
            @(negedge clk); chk_vo("t2_drain", 2'b10, 2'b10);
        end
        tick(); idle(2'b00);
        @(negedge clk); chk_vo("t2_done", 2'b00, 2'b00);

        // 3) fill VC0 without tail: escape availability, VC1 unaffected
        for (int i = 0; i < 4; i++) begin
            tick(); drive(1'b1, 1'b0, 1'b0, 64'h21 + 64'(i), 2'b00, 1'b1);
            @(negedge clk); chk_rdy("t3_fill", 1'b1);
        end
        tick(); drive(1'b1, 1'b0, 1'b0, 64'h25, 2'b00, 1'b0);
        @(negedge clk); chk_rdy("t3_full_vc0", 1'b0); chk_vo("t3_escape", 2'b01, 2'b01);
        #1; drive(1'b1, 1'b1, 1'b1, 64'h31, 2'b00, 1'b1);
        #1; chk_rdy("t3_vc1_same_cycle", 1'b1);
        tick(); idle(2'b00);
        @(negedge clk); chk_vo("t3_both", 2'b11, 2'b11);

        // 4) full VC0 popping while a push is offered: no pop-through
        tick(); drive(1'b1, 1'b0, 1'b1, 64'h26, 2'b01, 1'b0);
        @(negedge clk); chk_rdy("t4_reject", 1'b0);
        tick(); drive(1'b1, 1'b0, 1'b1, 64'h26, 2'b00, 1'b1);
        @(negedge clk); chk_rdy("t4_accept", 1'b1); chk_vo("t4_busy", 2'b11, 2'b11);
        tick(); idle(2'b00);
        @(negedge clk); chk_rdy("t4_full_again", 1'b0);

        // 5) tail push and tail pop on VC1 together
        tick(); drive(1'b1, 1'b1, 1'b1, 64'h32, 2'b10, 1'b1);
        @(negedge clk); chk_rdy("t5_push", 1'b1); chk_vo("t5_pre", 2'b11, 2'b11);
        tick(); idle(2'b00);
        @(negedge clk); chk_vo("t5_post", 2'b11, 2'b11);

        // 6) reset mid-packet: VC0 busy with two flits left
        tick(); idle(2'b01);
        tick(); idle(2'b01);
        tick(); idle(2'b00);
        @(negedge clk); chk_vo("t6_pre", 2'b11, 2'b11);
        check("t6_vc0_left", 65'(sb0.size()), 65'd2);
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        sb0.delete(); sb1.delete();
        @(negedge clk); chk_vo("t6_reset", 2'b00, 2'b00); chk_rdy("t6_reset", 1'b1);
        tick(); drive(1'b1, 1'b0, 1'b0, 64'h41, 2'b00, 1'b1);
        tick(); drive(1'b1, 1'b0, 1'b1, 64'h42, 2'b00, 1'b1);
        @(negedge clk); chk_vo("t6_head", 2'b01, 2'b00);
        tick(); idle(2'b00);
        @(negedge clk); chk_vo("t6_tail_in", 2'b01, 2'b01);
        tick(); idle(2'b01);
        tick(); idle(2'b01);
        tick(); idle(2'b00);
        @(negedge clk); chk_vo("t6_done", 2'b00, 2'b00);
        check("sb0_empty", 65'(sb0.size()), 65'd0);
        check("sb1_empty", 65'(sb1.size()), 65'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
